// File: rtl/decoder_3to8_pkg.sv
// Shared constants, code type and reference decode for the registered 3-to-8 decoder.
// Optional build macro DECODER_HOLD_EN is consumed by decoder_3to8.sv.
package decoder_3to8_pkg;

  localparam int DEC_IN_W  = 3;
  localparam int DEC_OUT_W = 8;

  typedef logic [DEC_IN_W-1:0]  dec_code_t;
  typedef logic [DEC_OUT_W-1:0] dec_line_t;

  // Active-high one-hot view of a code; polarity is applied downstream.
  function automatic dec_line_t dec_decode(input dec_code_t code);
    dec_line_t lines;
    lines       = '0;
    lines[code] = 1'b1;
    return lines;
  endfunction

endpackage

// File: rtl/decoder_3to8_if.sv
// Select/enable inputs and decoded outputs of the 3-to-8 decoder, bundled as one bus.
interface decoder_3to8_if;
  import decoder_3to8_pkg::*;

  logic      en;
  logic      a;
  logic      b;
  logic      c;
  dec_line_t out;
  logic      valid;

  modport master (output en, a, b, c, input out, valid);
  modport slave  (input en, a, b, c, output out, valid);

endinterface

// File: rtl/decoder_3to8_core.sv
// Purely combinational code-to-one-hot map, always active-high.
module decoder_3to8_core
  import decoder_3to8_pkg::*;
(
  input  dec_code_t code,
  output dec_line_t onehot
);

  dec_line_t ref_lines;

  assign ref_lines = dec_decode(code);

  // One comparator per line keeps the map a flat, obviously one-hot structure.
  generate
    for (genvar gi = 0; gi < DEC_OUT_W; gi++) begin : g_line
      assign onehot[gi] = (code == dec_code_t'(gi)) & ref_lines[gi];
    end
  endgenerate

endmodule

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 decoder with selectable output polarity.
// Build macro DECODER_HOLD_EN: en=0 holds the last decode instead of going idle.
module decoder_3to8
  import decoder_3to8_pkg::*;
#(
  parameter bit OUT_ACTIVE_LOW = 1'b0
)
(
  input  logic           clk,
  input  logic           rst,
  decoder_3to8_if.slave  bus
);

  localparam dec_line_t IDLE_LINES = OUT_ACTIVE_LOW ? dec_line_t'('1) : dec_line_t'('0);

  dec_code_t code;
  dec_line_t onehot;
  dec_line_t decoded;
  dec_line_t out_reg;
  dec_line_t out_next;
  logic      valid_reg;
  logic      valid_next;

  assign code = {bus.a, bus.b, bus.c};

  decoder_3to8_core u_core (
    .code   (code),
    .onehot (onehot)
  );

  assign decoded = onehot ^ {DEC_OUT_W{OUT_ACTIVE_LOW}};

  always_comb begin
    out_next   = IDLE_LINES;
    valid_next = bus.en;
    if (bus.en) begin
      out_next = decoded;
    end else begin
`ifdef DECODER_HOLD_EN
      out_next = out_reg;
`else
      out_next = IDLE_LINES;
`endif
    end
  end

  // Reset wins over enable on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg   <= IDLE_LINES;
      valid_reg <= 1'b0;
    end else begin
      out_reg   <= out_next;
      valid_reg <= valid_next;
    end
  end

  assign bus.out   = out_reg;
  assign bus.valid = valid_reg;

endmodule

// File: tb/tb_decoder_3to8.sv
// Self-checking bench: active-high and active-low decoders driven in lockstep against a line model.
module tb_decoder_3to8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  logic [7:0] exp_hi    = 8'h00;
  logic       exp_valid = 1'b0;
  int unsigned cur_code = 0;

  decoder_3to8_if bus_h ();
  decoder_3to8_if bus_l ();

  decoder_3to8 #(.OUT_ACTIVE_LOW(1'b0)) dut_h (.clk(clk), .rst(rst), .bus(bus_h));
  decoder_3to8 #(.OUT_ACTIVE_LOW(1'b1)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

  always #5 clk = ~clk;

  initial begin
    bus_h.en = 1'b0; bus_h.a = 1'b0; bus_h.b = 1'b0; bus_h.c = 1'b0;
    bus_l.en = 1'b0; bus_l.a = 1'b0; bus_l.b = 1'b0; bus_l.c = 1'b0;
  end

  // Drive one transaction, let junk settle to the real values before the edge,
  // advance the line model at the edge, then sample 1 ns later.
  task automatic tick(input logic r, input logic e, input int unsigned code);
    logic [2:0] junk;
    logic [2:0] cv;
    @(negedge clk);
    junk = 3'($urandom_range(0, 7));
    {bus_h.a, bus_h.b, bus_h.c} = junk; {bus_l.a, bus_l.b, bus_l.c} = junk;
    bus_h.en = ~e; bus_l.en = ~e;
    #2;
    cv = 3'(code);
    rst = r;
    bus_h.en = e; bus_l.en = e;
    {bus_h.a, bus_h.b, bus_h.c} = cv; {bus_l.a, bus_l.b, bus_l.c} = cv;
    cur_code = code;
    @(posedge clk);
    if (r) begin
      exp_hi = 8'h00; exp_valid = 1'b0;
    end else if (e) begin
      exp_hi = 8'(2 ** code); exp_valid = 1'b1;
    end else begin
`ifndef DECODER_HOLD_EN
      exp_hi = 8'h00;
`endif
      exp_valid = 1'b0;
    end
    #1;
    $display("t=%0t rst=%b en=%b code=%0d -> out_h=%h out_l=%h valid=%b%b",
             $time, r, e, code, bus_h.out, bus_l.out, bus_h.valid, bus_l.valid);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b1, 5);
      n_vec++;
      if (bus_h.out !== 8'h00 || bus_l.out !== 8'hFF || bus_h.valid !== 1'b0 || bus_l.valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset: out_h=%h out_l=%h valid=%b%b expected 00/FF valid=00",
                 bus_h.out, bus_l.out, bus_h.valid, bus_l.valid);
      end
    end
    tick(1'b0, 1'b1, 5);
    n_vec++;
    if (bus_h.out !== 8'h20 || bus_l.out !== 8'hDF || bus_h.valid !== 1'b1 || bus_l.valid !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release: out_h=%h out_l=%h valid=%b%b expected 20/DF valid=11",
               bus_h.out, bus_l.out, bus_h.valid, bus_l.valid);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] table_hi [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    for (int code = 0; code < 8; code++) begin
      for (int k = 0; k < 20; k++) begin
        tick(1'b0, 1'b1, code);
        n_vec++;
        if (bus_h.out !== table_hi[code] || bus_l.out !== ~table_hi[code] ||
            bus_h.valid !== 1'b1 || bus_l.valid !== 1'b1 || !$onehot(bus_h.out)) begin
          n_bad++;
          $display("FAIL sweep code=%0d: out_h=%h out_l=%h valid=%b%b expected %h/%h valid=11",
                   code, bus_h.out, bus_l.out, bus_h.valid, bus_l.valid, table_hi[code], ~table_hi[code]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned codes [4]    = '{3, 6, 0, 7};
    logic [7:0]  expect_v [4] = '{8'h08, 8'h40, 8'h01, 8'h80};
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, codes[i]);
      n_vec++;
      if (bus_h.out !== expect_v[i] || bus_l.out !== ~expect_v[i] || bus_h.valid !== 1'b1) begin
        n_bad++;
        $display("FAIL back_to_back step=%0d: out_h=%h out_l=%h valid=%b expected %h valid=1",
                 i, bus_h.out, bus_l.out, bus_h.valid, expect_v[i]);
      end
    end
  endtask

  task automatic test_enable_low();
    logic [7:0] want;
`ifdef DECODER_HOLD_EN
    want = 8'h10;
`else
    want = 8'h00;
`endif
    tick(1'b0, 1'b1, 4);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, $urandom_range(0, 7));
      n_vec++;
      if (bus_h.out !== want || bus_l.out !== ~want || bus_h.valid !== 1'b0 || bus_l.valid !== 1'b0) begin
        n_bad++;
        $display("FAIL enable_low cycle=%0d: out_h=%h out_l=%h valid=%b%b expected %h/%h valid=00",
                 i, bus_h.out, bus_l.out, bus_h.valid, bus_l.valid, want, ~want);
      end
    end
  endtask

  task automatic test_polarity();
    tick(1'b0, 1'b1, 2);
    n_vec++;
    if (bus_l.out !== 8'hFB || bus_h.out !== 8'h04) begin
      n_bad++;
      $display("FAIL polarity_code2: out_l=%h out_h=%h expected FB/04", bus_l.out, bus_h.out);
    end
    tick(1'b1, 1'b1, 2);
    n_vec++;
    if (bus_l.out !== 8'hFF || bus_h.out !== 8'h00) begin
      n_bad++;
      $display("FAIL polarity_reset: out_l=%h out_h=%h expected FF/00", bus_l.out, bus_h.out);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 6);
    tick(1'b1, 1'b1, 6);
    n_vec++;
    if (bus_h.out !== 8'h00 || bus_l.out !== 8'hFF || bus_h.valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midstream_reset: out_h=%h out_l=%h valid=%b expected 00/FF valid=0",
               bus_h.out, bus_l.out, bus_h.valid);
    end
    tick(1'b0, 1'b1, 6);
    n_vec++;
    if (bus_h.out !== 8'h40 || bus_l.out !== 8'hBF || bus_h.valid !== 1'b1) begin
      n_bad++;
      $display("FAIL midstream_resume: out_h=%h out_l=%h valid=%b expected 40/BF valid=1",
               bus_h.out, bus_l.out, bus_h.valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      tick(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 7));
      n_vec++;
      if (bus_h.out !== exp_hi || bus_l.out !== ~exp_hi ||
          bus_h.valid !== exp_valid || bus_l.valid !== exp_valid ||
          (exp_valid && !$onehot(bus_h.out))) begin
        n_bad++;
        $display("FAIL random i=%0d code=%0d: out_h=%h out_l=%h valid=%b%b expected %h/%h valid=%b",
                 i, cur_code, bus_h.out, bus_l.out, bus_h.valid, bus_l.valid, exp_hi, ~exp_hi, exp_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_back_to_back();
    test_enable_low();
    test_polarity();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_3to8.md
# decoder_3to8

Registered 3-to-8 line decoder. Three single-bit select inputs a (MSB), b and c (LSB) form a 3-bit code. The block drives exactly one of eight output lines to the asserted level, one clock after the code is sampled. It sits as a leaf utility between control logic and one-hot consumers such as chip-selects, LED banks and mux enables.

## Interface
- OUT_ACTIVE_LOW, default 0 — 0: selected line is 1 and the others are 0. 1: selected line is 0 and the others are 1. This is a global output inversion.
- clk  input  1  — single clock; all state updates on the rising edge.
- rst  input  1  — synchronous, active-high reset.
- en  input  1  — decode enable, sampled each rising edge.
- a  input  1  — code bit 2 (MSB).
- b  input  1  — code bit 1.
- c  input  1  — code bit 0 (LSB).
- out  output  8  — decoded lines. Bit index equals code {a,b,c}.
- valid  output  1  — high while out holds a decode of an enabled sample.

## Operation
- code = {a,b,c}, an unsigned value 0..7. No other width rules apply.
- Active-high view (OUT_ACTIVE_LOW=0): decoded value = 8'b0000_0001 << code.
  - code 0 -> 0000_0001
  - code 1 -> 0000_0010
  - code 2 -> 0000_0100
  - code 3 -> 0000_1000
  - code 4 -> 0001_0000
  - code 5 -> 0010_0000
  - code 6 -> 0100_0000
  - code 7 -> 1000_0000
- OUT_ACTIVE_LOW=1: out is the bitwise inverse of the value above.
- Edge with en=1: out is loaded with the decode of the sampled code, and valid is set to 1.
- Edge with en=0: behaviour depends on the macro (see Configuration). valid goes to 0 in both variants.
- The block has no state beyond the out and valid registers. There is no FSM.
- The decoded value is always exactly one-hot, or all-idle. Any other pattern is a design error.

## Timing
- Latency: 1 clock from a/b/c/en sampled to out/valid updated. There is no combinational path from input to output.
- Reset (rst=1 at an edge):
  - out = idle pattern: 8'h00 if OUT_ACTIVE_LOW=0, 8'hFF if OUT_ACTIVE_LOW=1.
  - valid = 0.
- rst has priority over en.
- Reset mid-operation: the output goes idle on the next edge. The first decode appears one edge after rst deasserts with en=1.
- A code change every cycle gives a new decode every cycle; full throughput with no stalls.
- Inputs that change between edges have no effect until the next sampling edge.
- Simultaneous rst=1 and en=1: the reset result applies.

## Configuration
- Macro DECODER_HOLD_EN.
- Defined: an en=0 edge holds out at its last value. valid still drops to 0.
- Undefined (default): an en=0 edge loads out with the idle pattern (all lines deasserted).

## Structure
- Shared package holds:
  - DEC_IN_W = 3 and DEC_OUT_W = 8 constants.
  - A dec_code_t typedef (3-bit).
  - A decode function returning the active-high one-hot value.
- One sub-module is natural: decoder_3to8_core. It is purely combinational, maps code to an active-high one-hot vector, and its output feeds the register and polarity stage.

## Test plan
- Reset: assert rst for 2 cycles with en=1 and code 5 -> out=8'h00 and valid=0 throughout; first edge after release gives out=8'h20 and valid=1.
- Sweep: en=1, apply codes 0..7 with each held 200 ns -> out matches 01,02,04,08,10,20,40,80 one cycle after each change; valid=1; $onehot(out) on every valid cycle.
- Back-to-back: change code every cycle 3,6,0,7 -> out = 08,40,01,80 on consecutive edges, with no bubbles.
- Enable low, code 4 then en=0 for 3 cycles:
  - without DECODER_HOLD_EN -> out=00.
  - with DECODER_HOLD_EN -> out stays 10.
  - valid=0 in both variants.
- Polarity: OUT_ACTIVE_LOW=1 and code 2 -> out=8'hFB; reset -> out=8'hFF.
- Reset mid-stream: rst pulsed for 1 cycle during the sweep at code 6 -> next edge out is idle and valid=0; the following edge resumes the decode of the current code.
